if_stage: RTL and testbench

// Instruction-fetch stage. Holds the PC, runs a one-outstanding-request handshake to instruction

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/if_stage_if.sv | 10 +
 rtl/if_skid_buf.sv | 29 ++
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, fetch state codes and jump-target helper
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef logic [2:0] if_state_t;
  localparam if_state_t S_IDLE    = 3'd0;
  localparam if_state_t S_FETCH   = 3'd1;
  localparam if_state_t S_HOLD    = 3'd2;
  localparam if_state_t S_DISCARD = 3'd3;
  localparam if_state_t S_HALT    = 3'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pair_t;

  // J/JAL: keep the 256 MB region of the delay-slot-free PC+4, word-align the index
  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/ack handshake bundle
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry {instr,pc} holding register for a fetch that lands during a stall
module if_skid_buf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  fetch_pair_t din,
  output fetch_pair_t dout,
  output logic        full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, one-outstanding imem handshake, IR/PC to decode
module if_stage #(
  parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        JMP,
  input  logic        JR,
  input  logic [31:0] jaddr,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] IR,
  output logic [31:0] PC_out,
  output logic [31:0] PC4,
  output logic        IR_valid
);
  import pipe_pkg::*;

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] disc_addr;
  logic        halt_pend;
  logic        got_ack;
  logic        pending;
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        skid_load;
  logic        skid_drain;
  logic        skid_clear;
  logic        skid_full;
  fetch_pair_t skid_in;
  fetch_pair_t skid_out;

  assign imem.req  = (state == S_FETCH) || (state == S_DISCARD);
  assign imem.addr = (state == S_DISCARD) ? disc_addr : pc;

  assign got_ack  = imem.req && imem.ack;
  assign pending  = imem.req && !imem.ack;
  assign redirect = IR_valid && !stall && (JR || JMP || branch_taken);

  always_comb begin
    if (JR)
      target_raw = jaddr;
    else if (JMP)
      target_raw = jump_target(PC4[31:28], jaddr[25:0]);
    else
      target_raw = branch_target;
  end
  assign target = target_raw & ~32'd3;

  assign skid_in    = {imem.rdata, pc};
  assign skid_clear = halt || redirect;
  assign skid_load  = (state == S_FETCH) && got_ack && stall && !skid_clear;
  assign skid_drain = (state == S_HOLD) && !stall && !skid_clear;

  if_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (skid_in),
    .dout  (skid_out),
    .full  (skid_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      disc_addr <= RESET_PC;
      halt_pend <= 1'b0;
      IR        <= NOP_INSTR;
      PC_out    <= RESET_PC;
      PC4       <= RESET_PC + 32'd4;
      IR_valid  <= 1'b0;
    end else if (state == S_HALT) begin
      IR_valid <= 1'b0;
    end else if (halt) begin
      IR       <= NOP_INSTR;
      IR_valid <= 1'b0;
      if (pending) begin
        state     <= S_DISCARD;
        halt_pend <= 1'b1;
        if (state == S_FETCH) disc_addr <= pc;
      end else begin
        state <= S_HALT;
      end
    end else if (redirect) begin
      IR       <= NOP_INSTR;
      IR_valid <= 1'b0;
      pc       <= target;
      // the request in flight still belongs to the old path; let it land and drop it
      if (pending) begin
        state <= S_DISCARD;
        if (state == S_FETCH) disc_addr <= pc;
      end else begin
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (got_ack) begin
            pc <= pc + 32'd4;
            if (stall) begin
              state <= S_HOLD;
            end else begin
              IR       <= imem.rdata;
              PC_out   <= pc;
              PC4      <= pc + 32'd4;
              IR_valid <= 1'b1;
            end
          end else if (!stall) begin
            IR       <= NOP_INSTR;
            IR_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if (skid_full) begin
              IR       <= skid_out.instr;
              PC_out   <= skid_out.pc;
              PC4      <= skid_out.pc + 32'd4;
              IR_valid <= 1'b1;
            end
            state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem.ack) state <= halt_pend ? S_HALT : S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, JMP, JR, branch_taken, halt;
  logic [31:0] jaddr, branch_target;
  logic [31:0] IR, PC_out, PC4;
  logic        IR_valid;

  if_stage_if imem();

  if_stage #(.RESET_PC(32'h0000_3000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem),
    .stall         (stall),
    .JMP           (JMP),
    .JR            (JR),
    .jaddr         (jaddr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .IR            (IR),
    .PC_out        (PC_out),
    .PC4           (PC4),
    .IR_valid      (IR_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        jr;
    logic        jmp;
    logic        br;
    logic [31:0] ja;
    logic [31:0] bt;
    logic [31:0] exp_pc;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          ack_mode;
  logic        ack_man;
  int          wait_cnt;
  int          cur_delay;
  logic        last_pend;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder plus one clock; returns #1 after the rising edge
  task automatic tick();
    if (ack_mode == 0)      imem.ack = imem.req;
    else if (ack_mode == 1) imem.ack = ack_man;
    else                    imem.ack = imem.req && (wait_cnt >= cur_delay);
    imem.rdata = imem.req ? mem_word(imem.addr) : 32'hDEAD_BEEF;
    last_pend  = imem.req && !imem.ack;
    last_addr  = imem.addr;
    if (imem.req && imem.ack) begin
      wait_cnt  = 0;
      cur_delay = $urandom_range(0, 3);
    end else if (imem.req) begin
      wait_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 0; JMP = 0; JR = 0; branch_taken = 0; halt = 0;
    jaddr = '0; branch_target = '0;
    imem.ack = 0; imem.rdata = '0; ack_man = 0;
    ack_mode = 0; wait_cnt = 0; cur_delay = 0; last_pend = 0; last_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20 && IR_valid !== 1'b1; k++) tick();
    chk(name, IR_valid, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vt [0:5];
    logic [31:0] exp_pc, hold_pc, hold_ir;
    logic        prev_hold;
    int          idle, delivered, r;

    vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h5555_5554, 32'h0000_1000};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_3021, 32'h0000_0000, 32'h0000_3020};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_4002, 32'h0000_4000};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0100, 32'hFFFF_FFFC};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0FFF_FFFC};
    vt[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'h0000_3008};

    // reset values, streaming, stall into the skid buffer
    do_reset();
    chk("rst_req", imem.req, 0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_valid", IR_valid, 0);
    chk("rst_pc_out", PC_out, 32'h3000);
    chk("rst_pc4", PC4, 32'h3004);
    tick();
    chk("first_req", imem.req, 1);
    chk("first_addr", imem.addr, 32'h3000);
    chk("first_valid", IR_valid, 0);
    tick();
    chk("s0_ir", IR, mem_word(32'h3000));
    chk("s0_pc", PC_out, 32'h3000);
    chk("s0_pc4", PC4, 32'h3004);
    chk("s0_valid", IR_valid, 1);
    tick();
    chk("s1_ir", IR, mem_word(32'h3004));
    chk("s1_addr", imem.addr, 32'h3008);
    stall = 1;
    tick();
    ack_mode = 1; ack_man = 1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", imem.req, 0);
      chk("hold_ir", IR, mem_word(32'h3004));
      chk("hold_pc", PC_out, 32'h3004);
      chk("hold_valid", IR_valid, 1);
      if (i < 2) tick();
    end
    stall = 0; ack_mode = 0;
    tick();
    chk("drain_ir", IR, mem_word(32'h3008));
    chk("drain_pc", PC_out, 32'h3008);
    chk("drain_pc4", PC4, 32'h300C);
    tick();
    chk("after_drain_ir", IR, mem_word(32'h300C));
    chk("after_drain_pc", PC_out, 32'h300C);

    // redirect table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      wait_valid("tbl_first_valid");
      tick();
      wait_valid("tbl_src_valid");
      chk("tbl_src_pc", PC_out, 32'h3004);
      JR = vt[i].jr; JMP = vt[i].jmp; branch_taken = vt[i].br;
      jaddr = vt[i].ja; branch_target = vt[i].bt;
      tick();
      JR = 0; JMP = 0; branch_taken = 0;
      wait_valid("tbl_target_valid");
      chk("tbl_target_pc", PC_out, vt[i].exp_pc);
      chk("tbl_target_ir", IR, mem_word(vt[i].exp_pc));
      tick();
      wait_valid("tbl_next_valid");
      chk("tbl_next_pc", PC_out, vt[i].exp_pc + 32'd4);
    end

    // JR while the fetch is still outstanding
    do_reset();
    tick(); tick();
    chk("jr_src_pc", PC_out, 32'h3000);
    ack_mode = 1; ack_man = 0;
    JR = 1; jaddr = 32'h0000_3021;
    tick();
    JR = 0;
    chk("jr_bubble", IR_valid, 0);
    chk("jr_disc_req", imem.req, 1);
    chk("jr_disc_addr", imem.addr, 32'h3004);
    tick(); tick();
    chk("jr_disc_addr2", imem.addr, 32'h3004);
    ack_man = 1;
    tick();
    chk("jr_dropped", IR_valid, 0);
    chk("jr_new_addr", imem.addr, 32'h3020);
    ack_mode = 0;
    tick();
    chk("jr_ir", IR, mem_word(32'h3020));
    chk("jr_pc", PC_out, 32'h3020);

    // halt with a request in flight
    do_reset();
    tick(); tick();
    ack_mode = 1; ack_man = 0; halt = 1;
    tick();
    halt = 0;
    chk("halt_valid", IR_valid, 0);
    chk("halt_wait_req", imem.req, 1);
    tick();
    chk("halt_wait_req2", imem.req, 1);
    ack_man = 1;
    tick();
    chk("halt_req_drop", imem.req, 0);
    ack_mode = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halted_req", imem.req, 0);
      chk("halted_valid", IR_valid, 0);
    end

    // asynchronous reset in the middle of a fetch
    do_reset();
    tick(); tick(); tick();
    ack_mode = 1; ack_man = 0;
    tick();
    chk("mid_req_before", imem.req, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_req", imem.req, 0);
    chk("async_addr", imem.addr, 32'h3000);
    chk("async_valid", IR_valid, 0);
    chk("async_pc_out", PC_out, 32'h3000);
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized traffic against an instruction-stream model
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      ack_mode = 2;
      exp_pc = 32'h3000; prev_hold = 0; idle = 0; delivered = 0;
      for (int c = 0; c < 700; c++) begin
        stall = ($urandom_range(0, 9) < 3);
        r = $urandom_range(0, 15);
        JR = (r == 0) || (r == 4);
        JMP = (r == 1) || (r == 4);
        branch_taken = (r == 2) || (r == 4) || (r == 5);
        jaddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        branch_target = $urandom;
        if (prev_hold) begin
          chk("rand_hold_valid", IR_valid, 1);
          chk("rand_hold_pc", PC_out, hold_pc);
          chk("rand_hold_ir", IR, hold_ir);
        end
        if (last_pend) begin
          chk("rand_req_held", imem.req, 1);
          chk("rand_addr_stable", imem.addr, last_addr);
        end
        if (!IR_valid) begin
          chk("rand_nop", IR, 32'h0);
        end
        if (IR_valid && !stall) begin
          chk("rand_pc", PC_out, exp_pc);
          chk("rand_ir", IR, mem_word(exp_pc));
          chk("rand_pc4", PC4, exp_pc + 32'd4);
          if (JR)
            exp_pc = jaddr & 32'hFFFF_FFFC;
          else if (JMP)
            exp_pc = ((exp_pc + 32'd4) & 32'hF000_0000) | ((jaddr & 32'h03FF_FFFF) << 2);
          else if (branch_taken)
            exp_pc = branch_target & 32'hFFFF_FFFC;
          else
            exp_pc = exp_pc + 32'd4;
          delivered++;
          idle = 0;
        end else begin
          idle++;
        end
        prev_hold = IR_valid && stall;
        hold_pc = PC_out;
        hold_ir = IR;
        tick();
        if (idle > 60) begin
          chk("rand_progress", idle, 0);
          break;
        end
      end
      chk("rand_delivered", delivered > 50, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
